// File: rtl/vjtag_regs_pkg.sv
// vjtag_regs: shared virtual JTAG IR command codes and read-path helpers
package vjtag_regs;

    localparam int VIR_W = 5;

    localparam logic [VIR_W-1:0] SET_TIME_CMD      = 5'h01;
    localparam logic [VIR_W-1:0] SET_ALARM_0_CMD   = 5'h02;
    localparam logic [VIR_W-1:0] SET_ALARM_1_CMD   = 5'h03;
    localparam logic [VIR_W-1:0] SET_ALARM_2_CMD   = 5'h04;
    localparam logic [VIR_W-1:0] SET_ALARM_3_CMD   = 5'h05;
    localparam logic [VIR_W-1:0] SET_ALARM_4_CMD   = 5'h06;
    localparam logic [VIR_W-1:0] SET_ALARM_5_CMD   = 5'h07;
    localparam logic [VIR_W-1:0] SET_ALARM_6_CMD   = 5'h08;
    localparam logic [VIR_W-1:0] UNSET_ALARM_0_CMD = 5'h09;
    localparam logic [VIR_W-1:0] UNSET_ALARM_1_CMD = 5'h0A;
    localparam logic [VIR_W-1:0] UNSET_ALARM_2_CMD = 5'h0B;
    localparam logic [VIR_W-1:0] UNSET_ALARM_3_CMD = 5'h0C;
    localparam logic [VIR_W-1:0] UNSET_ALARM_4_CMD = 5'h0D;
    localparam logic [VIR_W-1:0] UNSET_ALARM_5_CMD = 5'h0E;
    localparam logic [VIR_W-1:0] UNSET_ALARM_6_CMD = 5'h0F;

    // Read commands are contiguous so the source index is a plain offset
    localparam logic [VIR_W-1:0] GET_TIME_CMD      = 5'h10;
    localparam logic [VIR_W-1:0] GET_ALARM_0_CMD   = 5'h11;
    localparam logic [VIR_W-1:0] GET_ALARM_1_CMD   = 5'h12;
    localparam logic [VIR_W-1:0] GET_ALARM_2_CMD   = 5'h13;
    localparam logic [VIR_W-1:0] GET_ALARM_3_CMD   = 5'h14;
    localparam logic [VIR_W-1:0] GET_ALARM_4_CMD   = 5'h15;
    localparam logic [VIR_W-1:0] GET_ALARM_5_CMD   = 5'h16;
    localparam logic [VIR_W-1:0] GET_ALARM_6_CMD   = 5'h17;

    // Read DR: data, idx, timeout, valid
    localparam int RD_DR_LEN = 32 + 3 + 2;

    function automatic logic is_read_cmd(input logic [VIR_W-1:0] cmd);
        return cmd >= GET_TIME_CMD && cmd <= GET_ALARM_6_CMD;
    endfunction

    function automatic logic [2:0] cmd_to_idx(input logic [VIR_W-1:0] cmd);
        return 3'(cmd - GET_TIME_CMD);
    endfunction

endpackage

// File: rtl/vjtag_readback_toggle_sync.sv
// toggle_sync: two-flop synchroniser for a toggle signal plus a one-cycle edge pulse
module toggle_sync (
    input  logic clk,
    input  logic rst_i,
    input  logic d,
    output logic pulse
);

    logic [2:0] sync;

    // Two metastability flops followed by a history flop for edge detection
    always_ff @(posedge clk or posedge rst_i) begin
        if (rst_i) sync <= 3'b000;
        else       sync <= {sync[1:0], d};
    end

    assign pulse = sync[1] ^ sync[2];

endmodule

// File: rtl/vjtag_readback.sv
// vjtag_readback: JTAG-side snapshot request and serial readback of time/alarm values
module vjtag_readback
    import vjtag_regs::*;
#(
    parameter int IR_W    = 5,
    parameter int DATA_W  = 32,
    parameter int IDX_W   = 3,
    parameter int TIMEOUT = 1024
) (
    input  logic              jclk,
    input  logic              rst_i,
    input  logic              tdi_i,
    input  logic [IR_W-1:0]   ir_in_i,
    input  logic              cdr_i,
    input  logic              sdr_i,
    input  logic              uir_i,
    output logic              tdo_o,
    output logic              rd_active_o,
    output logic              req_tgl_o,
    output logic [IDX_W-1:0]  req_idx_o,
    input  logic              ack_tgl_i,
    input  logic [DATA_W-1:0] ack_data_i
);

    localparam int CNT_W = $clog2(TIMEOUT);
    localparam int SR_W  = DATA_W + IDX_W + 2;

    typedef enum logic [1:0] {IDLE, WAIT_ACK, READY} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [SR_W-1:0]   shift_reg;
    logic [DATA_W-1:0] hold_data;
    logic              valid, timeout;
    logic              ack_edge, cnt_done, req_go, take_ack, take_to;
    logic              unused_tdi;

    assign unused_tdi  = tdi_i;
    assign rd_active_o = is_read_cmd(VIR_W'(ir_in_i));
    assign tdo_o       = shift_reg[0];
    assign cnt_done    = cnt == CNT_W'(TIMEOUT - 1);
    assign req_go      = uir_i && rd_active_o && state != WAIT_ACK;

    toggle_sync u_ack_sync (
        .clk   (jclk),
        .rst_i (rst_i),
        .d     (ack_tgl_i),
        .pulse (ack_edge)
    );

    // State register
    always_ff @(posedge jclk or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    // New requests are only accepted outside WAIT_ACK; ack beats timeout
    always_comb begin
        state_nxt = state;
        if (req_go)                                         state_nxt = WAIT_ACK;
        else if (state == WAIT_ACK && (ack_edge || cnt_done)) state_nxt = READY;
    end

    // Completion actions decoded from the current state
    always_comb begin
        take_ack = state == WAIT_ACK && ack_edge;
        take_to  = state == WAIT_ACK && !ack_edge && cnt_done;
    end

    // Request handshake, snapshot capture and saturating timeout counter
    always_ff @(posedge jclk or posedge rst_i) begin
        if (rst_i) begin
            req_tgl_o <= 1'b0;
            req_idx_o <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
            hold_data <= '0;
            cnt       <= '0;
        end else begin
            if (req_go) begin
                req_tgl_o <= ~req_tgl_o;
                req_idx_o <= IDX_W'(cmd_to_idx(VIR_W'(ir_in_i)));
                valid     <= 1'b0;
                timeout   <= 1'b0;
                cnt       <= '0;
            end else if (take_ack) begin
                hold_data <= ack_data_i;
                valid     <= 1'b1;
            end else if (take_to) begin
                timeout   <= 1'b1;
            end
            if (state == WAIT_ACK && !cnt_done) cnt <= cnt + CNT_W'(1);
        end
    end

    // DR capture and LSB-first shift-out while a read command is selected
    always_ff @(posedge jclk or posedge rst_i) begin
        if (rst_i)                       shift_reg <= '0;
        else if (cdr_i && rd_active_o)   shift_reg <= {hold_data, req_idx_o, timeout, valid};
        else if (sdr_i && rd_active_o)   shift_reg <= {1'b0, shift_reg[SR_W-1:1]};
    end

endmodule

// File: tb/tb_vjtag_readback.sv
// tb_vjtag_readback: randomized and directed checks of the JTAG readback path
module tb_vjtag_readback;
    import vjtag_regs::*;

    localparam int T = 1024;
    localparam int L = 37;

    logic        jclk = 0, rst_i = 1, tdi_i = 0, cdr_i = 0, sdr_i = 0, uir_i = 0, ack_tgl_i = 0;
    logic [4:0]  ir_in_i = SET_TIME_CMD;
    logic [31:0] ack_data_i = 0;
    logic        tdo_o, rd_active_o, req_tgl_o;
    logic [2:0]  req_idx_o;

    int n_chk = 0, n_pass = 0;

    logic [4:0] rd_cmds [8] = '{GET_TIME_CMD, GET_ALARM_0_CMD, GET_ALARM_1_CMD, GET_ALARM_2_CMD,
                                GET_ALARM_3_CMD, GET_ALARM_4_CMD, GET_ALARM_5_CMD, GET_ALARM_6_CMD};

    vjtag_readback #(.TIMEOUT(T)) dut (
        .jclk        (jclk),
        .rst_i       (rst_i),
        .tdi_i       (tdi_i),
        .ir_in_i     (ir_in_i),
        .cdr_i       (cdr_i),
        .sdr_i       (sdr_i),
        .uir_i       (uir_i),
        .tdo_o       (tdo_o),
        .rd_active_o (rd_active_o),
        .req_tgl_o   (req_tgl_o),
        .req_idx_o   (req_idx_o),
        .ack_tgl_i   (ack_tgl_i),
        .ack_data_i  (ack_data_i)
    );

    always #5 jclk = ~jclk;

    function automatic int rd_idx(input logic [4:0] c);
        for (int i = 0; i < 8; i++) if (rd_cmds[i] == c) return i;
        return -1;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model: a request is outstanding from its UIR until an ack is seen
    // (ack toggles become visible two edges after being sampled) or T cycles pass.
    bit          m_wait = 0, ack_seen;
    logic        m_tgl = 0, m_valid = 0, m_to = 0;
    logic [2:0]  m_idx = 0, ah = 0;
    logic [31:0] m_data = 0;
    logic [L-1:0] m_sr = 0;
    int          cyc = 0, req_cyc = 0, k;

    always @(posedge jclk or posedge rst_i) begin
        if (rst_i) begin
            m_wait = 0; m_tgl = 0; m_idx = 0; m_valid = 0; m_to = 0;
            m_data = 0; m_sr = 0; ah = 0; cyc = 0; req_cyc = 0;
        end else begin
            cyc++;
            ack_seen = ah[1] ^ ah[2];
            if (cdr_i && rd_idx(ir_in_i) >= 0)      m_sr = {m_data, m_idx, m_to, m_valid};
            else if (sdr_i && rd_idx(ir_in_i) >= 0) m_sr = m_sr >> 1;
            k = rd_idx(ir_in_i);
            if (m_wait) begin
                if (ack_seen) begin
                    m_data = ack_data_i; m_valid = 1; m_wait = 0;
                end else if (cyc - req_cyc == T) begin
                    m_to = 1; m_wait = 0;
                end
            end else if (uir_i && k >= 0) begin
                m_tgl = ~m_tgl; m_idx = k[2:0]; m_valid = 0; m_to = 0;
                m_wait = 1; req_cyc = cyc;
            end
            ah = {ah[1:0], ack_tgl_i};
        end
    end

    // Every-cycle comparison of DUT outputs against the model
    always @(posedge jclk) begin
        #1;
        if (!rst_i) begin
            chk("rd_active", rd_active_o, rd_idx(ir_in_i) >= 0);
            chk("req_tgl", req_tgl_o, m_tgl);
            chk("req_idx", req_idx_o, m_idx);
            chk("tdo", tdo_o, m_sr[0]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge jclk);
    endtask

    task automatic uir_pulse(input logic [4:0] c);
        ir_in_i = c;
        uir_i = 1;
        @(negedge jclk);
        uir_i = 0;
    endtask

    task automatic ack(input logic [31:0] d);
        ack_data_i = d;
        ack_tgl_i = ~ack_tgl_i;
    endtask

    task automatic scan(output logic [L-1:0] w);
        cdr_i = 1;
        @(negedge jclk);
        cdr_i = 0;
        w[0] = tdo_o;
        sdr_i = 1;
        for (int i = 1; i < L; i++) begin
            @(negedge jclk);
            w[i] = tdo_o;
        end
        @(negedge jclk);
        sdr_i = 0;
    endtask

    initial begin
        logic [L-1:0] w;
        step(3);
        chk("rst_tgl", req_tgl_o, 0);
        chk("rst_idx", req_idx_o, 0);
        chk("rst_tdo", tdo_o, 0);
        chk("rst_rd_active", rd_active_o, 0);
        rst_i = 0;
        step(2);

        uir_pulse(GET_TIME_CMD);
        chk("time_tgl", req_tgl_o, 1);
        chk("time_idx", req_idx_o, 0);
        step(3); ack(32'h5F5E_1000); step(5);
        scan(w);
        chk("time_word", w, {32'h5F5E_1000, 3'd0, 1'b0, 1'b1});

        uir_pulse(GET_ALARM_6_CMD);
        chk("a6_tgl", req_tgl_o, 0);
        chk("a6_idx", req_idx_o, 7);
        step(2); ack(32'h0000_A8C0); step(5);
        scan(w);
        chk("a6_word", w, {32'h0000_A8C0, 3'd7, 1'b0, 1'b1});
        scan(w);
        chk("a6_rescan", w, {32'h0000_A8C0, 3'd7, 1'b0, 1'b1});

        uir_pulse(GET_ALARM_2_CMD);
        step(T + 4);
        scan(w);
        chk("timeout_word", w, {32'h0000_A8C0, 3'd3, 1'b1, 1'b0});

        uir_pulse(GET_ALARM_0_CMD);
        step(3);
        uir_pulse(GET_ALARM_4_CMD);
        chk("dup_tgl", req_tgl_o, 0);
        chk("dup_idx", req_idx_o, 1);
        scan(w);
        chk("early_word", w, {32'h0000_A8C0, 3'd1, 1'b0, 1'b0});
        ack(32'h1234_5678); step(5);
        scan(w);
        chk("late_word", w, {32'h1234_5678, 3'd1, 1'b0, 1'b1});

        uir_pulse(GET_TIME_CMD);
        step(T - 3); ack(32'hCAFE_F00D); step(6);
        scan(w);
        chk("ack_at_timeout", w, {32'hCAFE_F00D, 3'd0, 1'b0, 1'b1});

        uir_pulse(GET_ALARM_5_CMD);
        step(T - 2); ack(32'hDEAD_BEEF); step(6);
        scan(w);
        chk("ack_after_timeout", w, {32'hCAFE_F00D, 3'd6, 1'b1, 1'b0});

        uir_pulse(GET_ALARM_3_CMD);
        step(5);
        rst_i = 1;
        ack_tgl_i = 0;
        #1;
        chk("midrst_tgl", req_tgl_o, 0);
        chk("midrst_idx", req_idx_o, 0);
        chk("midrst_tdo", tdo_o, 0);
        @(negedge jclk);
        rst_i = 0;
        step(2);
        uir_pulse(GET_TIME_CMD);
        chk("postrst_tgl", req_tgl_o, 1);
        step(3); ack(32'h0BAD_CAFE); step(5);
        scan(w);
        chk("postrst_word", w, {32'h0BAD_CAFE, 3'd0, 1'b0, 1'b1});

        for (int it = 0; it < 24; it++) begin
            int dly;
            logic [4:0] c;
            c = ($urandom_range(3) == 0) ? 5'($urandom_range(31)) : rd_cmds[$urandom_range(7)];
            uir_pulse(c);
            if ($urandom_range(3) == 0) begin
                step(2);
                uir_pulse(rd_cmds[$urandom_range(7)]);
            end
            dly = ($urandom_range(3) == 0) ? -1 : int'($urandom_range(60));
            if (dly >= 0) begin
                step(dly);
                ack($urandom);
            end
            if ($urandom_range(1) == 1) scan(w);
            step(dly < 0 ? T + 4 : 8);
            if ($urandom_range(4) != 0) ir_in_i = rd_cmds[$urandom_range(7)];
            scan(w);
            if ($urandom_range(1) == 1) scan(w);
            if ($urandom_range(5) == 0) begin
                ack($urandom);
                step(4);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
